// File: rtl/pr_elastic_pipe.sv
// -----------------------------------------------------------------------------
// pr_elastic_pipe
//   Elastic pipeline register: a chain of DEPTH stages carrying a WIDTH-bit
//   payload with valid/ready handshakes on both sides. Entries collapse into
//   empty stages, a global stall holds all contents, and a per-stage flush
//   mask kills selected in-flight entries.
//
// Parameters
//   WIDTH         payload width (>= 1)
//   DEPTH         number of register stages (>= 1); stage 0 is the youngest,
//                 stage DEPTH-1 drives the output
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   i_valid       upstream entry present
//   i_data        upstream payload
//   o_in_ready    block accepts the upstream entry this cycle (combinational)
//   o_valid       output entry present (combinational from stall/flush)
//   o_data        output payload, stage DEPTH-1
//   i_out_ready   downstream consumes the output this cycle
//   i_stall       global hold
//   i_flush_mask  bit k kills the entry in stage k at this edge
//   o_count       number of valid stages
//
// Build option
//   PR_ELASTIC_COUNT_EN  when defined, o_count is a registered popcount of
//                        the next-state valids; otherwise o_count is tied to 0.
// -----------------------------------------------------------------------------
module pr_elastic_pipe #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_valid,
   input  logic [WIDTH-1:0]             i_data,
   output logic                         o_in_ready,
   output logic                         o_valid,
   output logic [WIDTH-1:0]             o_data,
   input  logic                         i_out_ready,
   input  logic                         i_stall,
   input  logic [DEPTH-1:0]             i_flush_mask,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   // Stage state
   logic [DEPTH-1:0] r_v;
   logic [WIDTH-1:0] r_d [DEPTH];

   // Effective valids, acceptance chain and next state
   logic [DEPTH-1:0] w_ev;
   logic [DEPTH:0]   w_acc;
   logic [DEPTH-1:0] w_v_nxt;
   logic [WIDTH-1:0] w_d_nxt [DEPTH];

   // Flushed entries neither forward nor block
   assign w_ev = r_v & ~i_flush_mask;

   // Acceptance chain from the output back to the input; w_acc[k] means
   // stage k can take a new entry at this edge.
   always_comb begin
      logic acc_run;
      w_acc        = '0;
      acc_run      = i_out_ready & ~i_stall;
      w_acc[DEPTH] = acc_run;
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
         acc_run  = ~i_stall & (~w_ev[k] | acc_run);
         w_acc[k] = acc_run;
      end
   end

   // Next state: take the source if it moves in, else hold a surviving entry
   // that cannot leave, else go empty with a zero payload.
   always_comb begin
      w_v_nxt = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
         w_d_nxt[k] = '0;
      end

      if (i_valid & w_acc[0]) begin
         w_v_nxt[0] = 1'b1;
         w_d_nxt[0] = i_data;
      end else if (w_ev[0] & ~w_acc[1]) begin
         w_v_nxt[0] = 1'b1;
         w_d_nxt[0] = r_d[0];
      end

      for (int k = 1; k < int'(DEPTH); k++) begin
         if (w_ev[k-1] & w_acc[k]) begin
            w_v_nxt[k] = 1'b1;
            w_d_nxt[k] = r_d[k-1];
         end else if (w_ev[k] & ~w_acc[k+1]) begin
            w_v_nxt[k] = 1'b1;
            w_d_nxt[k] = r_d[k];
         end
      end
   end

   // Stage registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v <= '0;
         for (int k = 0; k < int'(DEPTH); k++) begin
            r_d[k] <= '0;
         end
      end else begin
         r_v <= w_v_nxt;
         for (int k = 0; k < int'(DEPTH); k++) begin
            r_d[k] <= w_d_nxt[k];
         end
      end
   end

   assign o_in_ready = w_acc[0];
   assign o_valid    = w_ev[DEPTH-1] & ~i_stall;
   assign o_data     = r_d[DEPTH-1];

`ifdef PR_ELASTIC_COUNT_EN
   // Occupancy: popcount of next-state valids, so it tracks r_v exactly
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_nxt;

   always_comb begin
      w_count_nxt = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
         w_count_nxt = w_count_nxt + CW'(w_v_nxt[k]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_nxt;
      end
   end

   assign o_count = r_count;
`else
   assign o_count = '0;
`endif

endmodule
